counter_run_ctrl: RTL

Run/pause/clear controller that sequences the up/down display counter from front-panel button pulses. It replaces the free-running divided-clock counter with one counter register on the system clock, advanced by a single-cycle tick enable from an internal prescaler. The binary count output drives the existing binary-to-BCD converter and 4-digit FND controller. The blank output blinks the display while paused.

---
 rtl/counter_run_ctrl_pkg.sv | 10 +
 rtl/counter_run_ctrl_tick_prescaler.sv | 31 +++
 rtl/counter_run_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the run/pause/clear display-counter controller.
// State encoding is fixed so legacy display firmware can read it back unchanged.
package counter_run_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

endpackage

// File: rtl/counter_run_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV counter with enable and clear; emits a
// combinational one-cycle wrap pulse while enabled at terminal count.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // clr wins over en so a clear never leaks a partial prescale into the next run
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign wrap = en && (cnt == LAST);

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/pause/clear controller for the up/down display counter: one count register
// on the system clock, stepped by a prescaled tick, with blanking blink in PAUSE.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int N         = 12,
    parameter int COUNT_MAX = 4095,
    parameter int TICK_DIV  = 62_500_000,
    parameter int BLINK_DIV = 31_250_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_p,
    input  logic         clear_p,
    input  logic         dir_p,
    output logic [N-1:0] count,
    output logic         dir_up,
    output logic         running,
    output logic         tick,
    output logic         blank
);

    if (COUNT_MAX >= (2 ** N)) begin : g_bad_max
        $error("COUNT_MAX must be below 2**N");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be at least 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink
        $error("BLINK_DIV must be at least 2");
    end

    localparam logic [N-1:0] CMAX = N'(COUNT_MAX);

    // Wrapping step: never produces a value above CMAX in either direction
    function automatic logic [N-1:0] step_count(input logic [N-1:0] c, input logic up);
        if (up) begin
            return (c == CMAX) ? '0 : c + 1'b1;
        end
        return (c == '0) ? CMAX : c - 1'b1;
    endfunction

    logic [1:0] state;
    logic       in_run;
    logic       in_pause;
    logic       leave_pause;
    logic       tick_clr;
    logic       blink_clr;
    logic       tick_wrap;
    logic       blink_wrap;

    assign in_run      = (state == ST_RUN);
    assign in_pause    = (state == ST_PAUSE);
    assign leave_pause = in_pause && (start_p || clear_p);

    // Count prescaler is only frozen (not cleared) across PAUSE so a resume keeps phase
    assign tick_clr  = clear_p || !(in_run || in_pause);
    assign blink_clr = !in_pause || leave_pause;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (in_run),
        .clr  (tick_clr),
        .wrap (tick_wrap)
    );

    tick_prescaler #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (in_pause),
        .clr  (blink_clr),
        .wrap (blink_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            dir_up <= 1'b1;
        end else begin
            if (dir_p) begin
                dir_up <= ~dir_up;
            end
            case (state)
                ST_IDLE: begin
                    if (clear_p) begin
                        count <= '0;
                    end else if (start_p) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear_p) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else begin
                        // a tick coinciding with start_p or dir_p still steps, with the old direction
                        if (tick_wrap) begin
                            count <= step_count(count, dir_up);
                        end
                        if (start_p) begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clear_p) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end else if (start_p) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blank <= 1'b0;
        end else if (!in_pause || leave_pause) begin
            blank <= 1'b0;
        end else if (blink_wrap) begin
            blank <= ~blank;
        end
    end

    assign running = in_run;
    assign tick    = tick_wrap;

endmodule
